// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud/oversample constants.
// Also used by the transmitter top so both ends agree on timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int BAUD_DIV_DEFAULT = 54;
  localparam int OVERSAMPLE       = 16;
  localparam int START_MID        = 7;
  localparam int BIT_END          = OVERSAMPLE - 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; resets to 1.
// Latency: 2 clocks; no backpressure.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; Rx_valid/Frame_error pulse one clock after the stop sample.
// Latency: ~8211-8265 clocks from start edge at BAUD_DIV=54; no backpressure, strobes are not held.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Rx_in,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_valid,
  output logic                 Frame_error,
  output logic                 Rx_busy
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [8:0]     TICK_LAST = 9'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [8:0]           tick_cnt;
  logic                 tick;
  rx_state_t            state, state_nxt;
  logic [3:0]           s_cnt, s_cnt_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;

  uart_rx_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (Rx_in),
    .sync_out (rx_s)
  );

  // Free-running oversample tick, independent of frame activity.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 9'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      Rx_data     <= '0;
      Rx_valid    <= 1'b0;
      Frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      s_cnt       <= s_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      Rx_data     <= data_nxt;
      Rx_valid    <= valid_nxt;
      Frame_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    s_cnt_nxt   = s_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    data_nxt    = Rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            s_cnt_nxt = '0;
          end
        end
        START: begin
          s_cnt_nxt = s_cnt + 4'd1;
          // Mid-start-bit check rejects short low glitches.
          if (s_cnt == 4'(START_MID)) begin
            if (!rx_s) begin
              state_nxt   = DATA;
              s_cnt_nxt   = '0;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          s_cnt_nxt = s_cnt + 4'd1;
          if (s_cnt == 4'(BIT_END)) begin
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            s_cnt_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + BCW'(1);
            end
          end
        end
        STOP: begin
          s_cnt_nxt = s_cnt + 4'd1;
          if (s_cnt == 4'(BIT_END)) begin
            if (rx_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be re-read as a new start bit.
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Rx_busy = (state != IDLE);

endmodule
